// File: rtl/cvxif_copro_responder.sv
// CV-X-IF style coprocessor responder: custom-3 ADD/MUL/NOP with a multi-cycle
// multiplier and an in-order result FIFO toward the core.
module cvxif_copro_responder #(
  parameter int XLEN       = 64,
  parameter int IdWidth    = 3,
  parameter int FifoDepth  = 4,
  parameter int MulLatency = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);
  localparam int LatW = (MulLatency > 1) ? $clog2(MulLatency) : 1;
  localparam logic [CntW-1:0] FIFO_FULL   = CntW'(FifoDepth);
  localparam logic [LatW-1:0] LAT_LOAD    = LatW'(MulLatency - 1);
  localparam logic [6:0]      OPC_CUSTOM3 = 7'b1111011;
  localparam logic [2:0]      F3_ADD      = 3'd0;
  localparam logic [2:0]      F3_MUL      = 3'd2;
  localparam logic [2:0]      F3_NOP      = 3'd3;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic [XLEN-1:0] add_wrap(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return a + b;
  endfunction

  function automatic logic [XLEN-1:0] mul_low(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return a * b;
  endfunction

  state_e              state_q, state_d;
  logic [LatW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     op_a_q, op_b_q;
  logic [IdWidth-1:0]  mul_id_q;
  logic [4:0]          mul_rd_q;

  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q;
  logic [IdWidth-1:0]  id_mem_q   [FifoDepth];
  logic [4:0]          rd_mem_q   [FifoDepth];
  logic [XLEN-1:0]     data_mem_q [FifoDepth];

  logic [2:0]          funct3;
  logic                legal, handshake, add_go, mul_go, mul_done, push, pop;
  logic [IdWidth-1:0]  push_id;
  logic [4:0]          push_rd;
  logic [XLEN-1:0]     push_data;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^issue_instr_i[24:15];

  // Decode and issue handshake
  assign funct3 = issue_instr_i[14:12];
  assign legal  = (issue_instr_i[6:0] == OPC_CUSTOM3) && (issue_instr_i[31:25] == 7'd0) &&
                  ((funct3 == F3_ADD) || (funct3 == F3_MUL) || (funct3 == F3_NOP));

  assign issue_ready_o     = (state_q == IDLE) && (count_q < FIFO_FULL) &&
                             (issue_rs_valid_i == 2'b11) && !flush_i && !rst_i;
  assign handshake         = issue_valid_i && issue_ready_o;
  assign issue_accept_o    = handshake && legal;
  assign issue_writeback_o = issue_accept_o && (funct3 != F3_NOP);
  assign add_go            = issue_accept_o && (funct3 == F3_ADD);
  assign mul_go            = issue_accept_o && (funct3 == F3_MUL);
  assign mul_done          = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (mul_go) begin
          state_d = BUSY;
          cnt_d   = LAT_LOAD;
        end
        BUSY: if (cnt_q == '0) state_d = IDLE;
              else             cnt_d   = cnt_q - 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiplier operand hold; stays frozen for the whole BUSY window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      mul_id_q <= '0;
      mul_rd_q <= '0;
    end else if (mul_go) begin
      op_a_q   <= issue_rs1_i;
      op_b_q   <= issue_rs2_i;
      mul_id_q <= issue_id_i;
      mul_rd_q <= issue_instr_i[11:7];
    end
  end

  // Result FIFO: ADD and MUL completion never coincide since ADD needs IDLE
  assign push      = !flush_i && (add_go || mul_done);
  assign pop       = result_valid_o && result_ready_i && !flush_i;
  assign push_id   = add_go ? issue_id_i : mul_id_q;
  assign push_rd   = add_go ? issue_instr_i[11:7] : mul_rd_q;
  assign push_data = add_go ? add_wrap(issue_rs1_i, issue_rs2_i) : mul_low(op_a_q, op_b_q);

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem_q[wptr_q]   <= push_id;
      rd_mem_q[wptr_q]   <= push_rd;
      data_mem_q[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields are masked when empty so stale storage never leaks out
  assign result_valid_o = (count_q != '0);
  assign result_id_o    = result_valid_o ? id_mem_q[rptr_q]   : '0;
  assign result_rd_o    = result_valid_o ? rd_mem_q[rptr_q]   : '0;
  assign result_data_o  = result_valid_o ? data_mem_q[rptr_q] : '0;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Bench for cvxif_copro_responder: directed scenarios plus randomized traffic,
// with a queue-based scoreboard drained by an independent result monitor.
module tb_cvxif_copro_responder;

  localparam logic [6:0] C3 = 7'b1111011;

  logic        clk = 1'b0;
  logic        rst, flush, iv, irdy, acc, wbo, rv, rr;
  logic [31:0] instr;
  logic [2:0]  iid, rid;
  logic [63:0] rs1, rs2, rdata;
  logic [1:0]  rsv;
  logic [4:0]  rrd;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [63:0] data;
  } res_t;

  res_t sbq[$];
  res_t mon_e;

  cvxif_copro_responder #(.XLEN(64), .IdWidth(3), .FifoDepth(4), .MulLatency(3)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(iv), .issue_ready_o(irdy), .issue_instr_i(instr), .issue_id_i(iid),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_rs_valid_i(rsv),
    .issue_accept_o(acc), .issue_writeback_o(wbo),
    .result_valid_o(rv), .result_ready_i(rr), .result_id_o(rid),
    .result_rd_o(rrd), .result_data_o(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [9:0] rsf,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {f7, rsf, f3, rd, opc};
  endfunction

  // Reference: ADD wraps mod 2^64, MUL keeps the low 64 bits of the unsigned product
  function automatic void push_exp(input logic [31:0] ins, input logic [2:0] i_id,
                                   input logic [63:0] a, input logic [63:0] b);
    res_t e;
    e.id   = i_id;
    e.rd   = ins[11:7];
    e.data = (ins[14:12] == 3'd0) ? a + b : a * b;
    sbq.push_back(e);
  endfunction

  // Monitor: every result the core takes must be the oldest expected one
  always @(negedge clk) begin
    if (!rst && !flush && rv && rr) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id=%0d rd=%0d data=%0h expected none", rid, rrd, rdata);
      end else begin
        mon_e = sbq.pop_front();
        check("result", {rid, rrd, rdata}, mon_e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [2:0] i_id, input logic [63:0] a,
                       input logic [63:0] b, input logic [1:0] v,
                       output logic rdy_s, output logic acc_s, output logic wb_s);
    logic       lg;
    logic [2:0] f3;
    instr = ins; iid = i_id; rs1 = a; rs2 = b; rsv = v; iv = 1'b1;
    @(negedge clk);
    rdy_s = irdy; acc_s = acc; wb_s = wbo;
    f3 = ins[14:12];
    lg = (ins[6:0] == C3) && (ins[31:25] == 7'd0) && (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd3);
    check("accept_rule", acc_s, rdy_s & lg);
    check("writeback_rule", wb_s, acc_s & (f3 != 3'd3));
    if (v != 2'b11) check("ready_rs_valid", rdy_s, 1'b0);
    if (acc_s && f3 != 3'd3) push_exp(ins, i_id, a, b);
    cyc();
    iv = 1'b0;
    rsv = 2'b11;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && sbq.size() != 0; i++) cyc();
    check("drain_empty", sbq.size(), 0);
    @(negedge clk);
    check("drained_valid", rv, 1'b0);
    cyc();
  endtask

  initial begin
    logic r_, a_, w_;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic [1:0] v;
    int sel;
    rst = 1'b1; flush = 1'b0; iv = 1'b0; instr = '0; iid = '0;
    rs1 = '0; rs2 = '0; rsv = 2'b11; rr = 1'b1;

    // Reset behaviour
    cyc();
    iv = 1'b1; instr = enc(7'd0, 10'd0, 3'd0, 5'd1, C3);
    @(negedge clk);
    check("ready_in_reset", irdy, 1'b0);
    cyc();
    rst = 1'b0; iv = 1'b0;
    @(negedge clk);
    check("reset_outputs", {rv, rid, rrd, rdata, acc, wbo}, '0);
    check("ready_after_reset", irdy, 1'b1);
    cyc();

    // ADD 5+7 -> 12, one cycle later
    offer(enc(7'd0, 10'd0, 3'd0, 5'd10, C3), 3'd2, 64'd5, 64'd7, 2'b11, r_, a_, w_);
    check("add_accept_wb", {a_, w_}, 2'b11);
    @(negedge clk);
    check("add_result", {rv, rid, rrd, rdata}, {1'b1, 3'd2, 5'd10, 64'd12});
    cyc();

    // MUL 2^32 * (2^32+3): busy for 3 cycles, result in the 4th
    offer(enc(7'd0, 10'd0, 3'd2, 5'd3, C3), 3'd1, 64'h1_0000_0000, 64'h1_0000_0003, 2'b11, r_, a_, w_);
    check("mul_accept_wb", {a_, w_}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mul_busy_ready_valid", {irdy, rv}, 2'b00);
      cyc();
    end
    @(negedge clk);
    check("mul_result", {rv, rid, rrd, rdata}, {1'b1, 3'd1, 5'd3, 64'h3_0000_0000});
    cyc();

    // Boundary encodings
    offer(enc(7'd0, 10'd0, 3'd1, 5'd4, C3), 3'd5, 64'd1, 64'd1, 2'b11, r_, a_, w_);
    check("f3_1_ready", r_, 1'b1);
    check("f3_1_accept_wb", {a_, w_}, 2'b00);
    @(negedge clk);
    check("f3_1_no_result", rv, 1'b0);
    cyc();
    offer(enc(7'd0, 10'd0, 3'd3, 5'd6, C3), 3'd6, 64'd9, 64'd9, 2'b11, r_, a_, w_);
    check("nop_accept_wb", {a_, w_}, 2'b10);
    @(negedge clk);
    check("nop_no_result", rv, 1'b0);
    cyc();
    offer(enc(7'd0, 10'd0, 3'd0, 5'd6, C3), 3'd6, 64'd1, 64'd2, 2'b01, r_, a_, w_);
    check("rs_valid_01_ready_accept", {r_, a_}, 2'b00);

    // FIFO full, then pop with a simultaneous offer
    rr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(enc(7'd0, 10'd0, 3'd0, 5'(k + 1), C3), 3'(k), 64'(k * 100), 64'(k), 2'b11, r_, a_, w_);
      check("fill_accept", a_, 1'b1);
    end
    instr = enc(7'd0, 10'd0, 3'd0, 5'd20, C3); iid = 3'd4; rs1 = 64'd1000; rs2 = 64'd1; iv = 1'b1;
    @(negedge clk);
    check("full_ready_accept", {irdy, acc}, 2'b00);
    cyc();
    rr = 1'b1;
    @(negedge clk);
    check("pop_cycle_ready", irdy, 1'b0);
    cyc();
    rr = 1'b0;
    @(negedge clk);
    check("after_pop_ready_accept", {irdy, acc}, 2'b11);
    if (acc) push_exp(instr, 3'd4, 64'd1000, 64'd1);
    cyc();
    iv = 1'b0; rr = 1'b1;
    drain(20);

    // Flush in the last BUSY cycle with two results queued
    rr = 1'b0;
    offer(enc(7'd0, 10'd0, 3'd0, 5'd11, C3), 3'd5, 64'd3, 64'd4, 2'b11, r_, a_, w_);
    offer(enc(7'd0, 10'd0, 3'd0, 5'd12, C3), 3'd6, 64'd8, 64'd9, 2'b11, r_, a_, w_);
    offer(enc(7'd0, 10'd0, 3'd2, 5'd13, C3), 3'd7, 64'd77, 64'd88, 2'b11, r_, a_, w_);
    check("flush_setup_mul_accept", a_, 1'b1);
    cyc();
    cyc();
    flush = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("flush_cycle_ready", irdy, 1'b0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_valid_ready", {rv, irdy}, 2'b01);
    cyc();
    rr = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    check("no_mul_after_flush", rv, 1'b0);
    cyc();

    // Reset mid-MUL with three results queued
    rr = 1'b0;
    for (int k = 0; k < 3; k++)
      offer(enc(7'd0, 10'd0, 3'd0, 5'(k + 20), C3), 3'(k), 64'(k), 64'd5, 2'b11, r_, a_, w_);
    offer(enc(7'd0, 10'd0, 3'd2, 5'd25, C3), 3'd3, 64'd6, 64'd7, 2'b11, r_, a_, w_);
    check("rst_setup_mul_accept", a_, 1'b1);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("ready_during_rst", irdy, 1'b0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", {rv, rid, rrd, rdata, acc, wbo}, '0);
    check("post_rst_ready", irdy, 1'b1);
    cyc();
    rr = 1'b1;
    offer(enc(7'd0, 10'd0, 3'd0, 5'd7, C3), 3'd3, 64'd123, 64'd456, 2'b11, r_, a_, w_);
    check("post_rst_add_accept", a_, 1'b1);
    @(negedge clk);
    check("post_rst_add_result", {rv, rid, rrd, rdata}, {1'b1, 3'd3, 5'd7, 64'd579});
    cyc();
    repeat (6) cyc();
    drain(10);

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      rr  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      f7  = 7'd0;
      opc = C3;
      if (sel <= 3)      f3 = 3'd0;
      else if (sel <= 5) f3 = 3'd2;
      else if (sel == 6) f3 = 3'd3;
      else if (sel == 7) f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom_range(4, 7));
      else if (sel == 8) begin f3 = 3'd0; f7 = 7'($urandom_range(1, 127)); end
      else               begin f3 = 3'd0; opc = 7'h33; end
      v = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      if ($urandom_range(0, 4) == 0) cyc();
      else offer(enc(f7, 10'($urandom), f3, 5'($urandom), opc), 3'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, v, r_, a_, w_);
    end
    rr = 1'b1;
    drain(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
